// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller: CSR read-modify-write, 64-bit counters,
// prioritised interrupt entry and mret return through a RUN/SETTLE redirect FSM.
module csr_trap_unit #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned NUM_PLAT_IRQ = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [XLEN-1:0]         pc,
    input  logic                    csr_valid,
    input  logic [2:0]              func3,
    input  logic [11:0]             address,
    input  logic [XLEN-1:0]         wdata,
    input  logic                    is_mret,
    input  logic                    instr_retire,
    input  logic                    can_take,
    input  logic                    timer_irq,
    input  logic                    ext_irq,
    input  logic [NUM_PLAT_IRQ-1:0] plat_irq,
    output logic [XLEN-1:0]         rd_data,
    output logic                    illegal_csr,
    output logic                    excep_taken,
    output logic [XLEN-1:0]         excep_pc
);

    localparam int unsigned CW = 2 * XLEN;

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;

    localparam logic [XLEN-1:0] PLAT_MASK  = XLEN'(((1 << NUM_PLAT_IRQ) - 1) << 16);
    localparam logic [XLEN-1:0] MIE_MASK   = XLEN'(32'h0000_0888) | PLAT_MASK;
    localparam logic [XLEN-1:0] MTVEC_MASK = XLEN'(32'hFFFF_FFFD);
    localparam logic [XLEN-1:0] MEPC_MASK  = XLEN'(32'hFFFF_FFFC);

    typedef enum logic {RUN, SETTLE} state_e;

    state_e                  state_q, state_d;
    logic                    mstat_mie_q, mstat_mie_d;
    logic                    mstat_mpie_q, mstat_mpie_d;
    logic [XLEN-1:0]         mie_q, mie_d;
    logic [XLEN-1:0]         mtvec_q, mtvec_d;
    logic [XLEN-1:0]         mscratch_q, mscratch_d;
    logic [XLEN-1:0]         mepc_q, mepc_d;
    logic [XLEN-1:0]         mcause_q, mcause_d;
    logic                    msip_q, msip_d;
    logic                    timer_q, timer_d;
    logic                    ext_q, ext_d;
    logic [NUM_PLAT_IRQ-1:0] plat_q, plat_d;
    logic [CW-1:0]           mcycle_q, mcycle_d;
    logic [CW-1:0]           minstret_q, minstret_d;

    logic [XLEN-1:0] mstatus_rd, mip_rd, pend, old, wval, mtvec_base;
    logic            csr_impl, op_write, wr_en, take_mret, take_irq;
    logic [4:0]      irq_code;

    // Architectural views of the partially implemented registers
    always_comb begin
        mstatus_rd        = '0;
        mstatus_rd[12:11] = 2'b11;
        mstatus_rd[7]     = mstat_mpie_q;
        mstatus_rd[3]     = mstat_mie_q;
        mip_rd                     = '0;
        mip_rd[3]                  = msip_q;
        mip_rd[7]                  = timer_q;
        mip_rd[11]                 = ext_q;
        mip_rd[16 +: NUM_PLAT_IRQ] = plat_q;
    end

    always_comb begin
        old      = '0;
        csr_impl = 1'b1;
        case (address)
            A_MSTATUS:   old = mstatus_rd;
            A_MIE:       old = mie_q;
            A_MTVEC:     old = mtvec_q;
            A_MSCRATCH:  old = mscratch_q;
            A_MEPC:      old = mepc_q;
            A_MCAUSE:    old = mcause_q;
            A_MIP:       old = mip_rd;
            A_MCYCLE:    old = mcycle_q[XLEN-1:0];
            A_MCYCLEH:   old = mcycle_q[CW-1:XLEN];
            A_MINSTRET:  old = minstret_q[XLEN-1:0];
            A_MINSTRETH: old = minstret_q[CW-1:XLEN];
            default:     csr_impl = 1'b0;
        endcase
    end

    assign rd_data     = (csr_valid && csr_impl) ? old : '0;
    assign illegal_csr = csr_valid && !csr_impl;

    // Set/clear with a zero operand is a pure read
    always_comb begin
        op_write = 1'b0;
        wval     = wdata;
        case (func3)
            3'b001, 3'b101: op_write = 1'b1;
            3'b010, 3'b110: begin op_write = |wdata; wval = old | wdata;  end
            3'b011, 3'b111: begin op_write = |wdata; wval = old & ~wdata; end
            default: ;
        endcase
    end

    assign pend = mip_rd & mie_q;

    // Lowest platform line wins among platform interrupts, so scan downwards
    always_comb begin
        irq_code = '0;
        if (pend[11])     irq_code = 5'd11;
        else if (pend[3]) irq_code = 5'd3;
        else if (pend[7]) irq_code = 5'd7;
        else begin
            for (int i = int'(NUM_PLAT_IRQ) - 1; i >= 0; i--) begin
                if (pend[16+i]) irq_code = 5'(16 + i);
            end
        end
    end

    assign take_mret   = (state_q == RUN) && is_mret;
    assign take_irq    = (state_q == RUN) && !is_mret && mstat_mie_q && (|pend) && can_take;
    assign excep_taken = take_mret || take_irq;
    assign wr_en       = csr_valid && csr_impl && op_write && !excep_taken;
    assign mtvec_base  = {mtvec_q[XLEN-1:2], 2'b00};

    always_comb begin
        if (take_mret)       excep_pc = mepc_q;
        else if (mtvec_q[0]) excep_pc = mtvec_base + XLEN'({irq_code, 2'b00});
        else                 excep_pc = mtvec_base;
    end

    always_comb begin
        state_d      = excep_taken ? SETTLE : RUN;
        mstat_mie_d  = mstat_mie_q;
        mstat_mpie_d = mstat_mpie_q;
        mie_d        = mie_q;
        mtvec_d      = mtvec_q;
        mscratch_d   = mscratch_q;
        mepc_d       = mepc_q;
        mcause_d     = mcause_q;
        msip_d       = msip_q;
        timer_d      = timer_irq;
        ext_d        = ext_irq;
        plat_d       = plat_irq;
        mcycle_d     = mcycle_q + CW'(1);
        minstret_d   = (instr_retire && !excep_taken) ? minstret_q + CW'(1) : minstret_q;

        if (wr_en) begin
            case (address)
                A_MSTATUS:   begin mstat_mie_d = wval[3]; mstat_mpie_d = wval[7]; end
                A_MIE:       mie_d = wval & MIE_MASK;
                A_MTVEC:     mtvec_d = wval & MTVEC_MASK;
                A_MSCRATCH:  mscratch_d = wval;
                A_MEPC:      mepc_d = wval & MEPC_MASK;
                A_MCAUSE:    mcause_d = wval;
                A_MIP:       msip_d = wval[3];
                A_MCYCLE:    mcycle_d[XLEN-1:0] = wval;
                A_MCYCLEH:   mcycle_d[CW-1:XLEN] = wval;
                A_MINSTRET:  minstret_d[XLEN-1:0] = wval;
                A_MINSTRETH: minstret_d[CW-1:XLEN] = wval;
                default: ;
            endcase
        end

        if (take_mret) begin
            mstat_mie_d  = mstat_mpie_q;
            mstat_mpie_d = 1'b1;
        end else if (take_irq) begin
            mepc_d       = pc & MEPC_MASK;
            mcause_d     = {1'b1, {(XLEN-6){1'b0}}, irq_code};
            mstat_mpie_d = mstat_mie_q;
            mstat_mie_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= RUN;
            mstat_mie_q  <= 1'b0;
            mstat_mpie_q <= 1'b0;
            mie_q        <= '0;
            mtvec_q      <= '0;
            mscratch_q   <= '0;
            mepc_q       <= '0;
            mcause_q     <= '0;
            msip_q       <= 1'b0;
            timer_q      <= 1'b0;
            ext_q        <= 1'b0;
            plat_q       <= '0;
            mcycle_q     <= '0;
            minstret_q   <= '0;
        end else begin
            state_q      <= state_d;
            mstat_mie_q  <= mstat_mie_d;
            mstat_mpie_q <= mstat_mpie_d;
            mie_q        <= mie_d;
            mtvec_q      <= mtvec_d;
            mscratch_q   <= mscratch_d;
            mepc_q       <= mepc_d;
            mcause_q     <= mcause_d;
            msip_q       <= msip_d;
            timer_q      <= timer_d;
            ext_q        <= ext_d;
            plat_q       <= plat_d;
            mcycle_q     <= mcycle_d;
            minstret_q   <= minstret_d;
        end
    end

endmodule

// File: doc/csr_trap_unit.md
# csr_trap_unit

Parametrised machine-mode CSR and trap controller, successor to the single-cycle CSR file. It adds full CSRRW/RS/RC(I) read-modify-write semantics, MIE/MPIE save and restore, and a prioritised set of N platform interrupt lines. It also adds 64-bit mcycle/minstret counters and a two-state trap FSM that prevents back-to-back redirects. It sits beside the execute stage: it receives CSR accesses and retire/mret strobes, and drives the PC-redirect inputs of the fetch stage.

## Interface
- XLEN, 32: datapath width; only 32 is supported, and counters are split into low/high halves.
- NUM_PLAT_IRQ, 4: platform interrupt lines, 1..16, mapped to mip/mie bits [16+NUM_PLAT_IRQ-1:16].
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low.
- pc  in  XLEN  PC of the oldest un-retired instruction; saved to mepc on interrupt.
- csr_valid  in  1  a CSR instruction is in execute this cycle.
- func3  in  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- address  in  12  CSR address.
- wdata  in  XLEN  rs1 value, or zimm zero-extended upstream.
- is_mret  in  1  mret in execute.
- instr_retire  in  1  one instruction retires this cycle.
- can_take  in  1  pipeline can accept a redirect this cycle.
- timer_irq, ext_irq  in  1 each  level interrupt requests.
- plat_irq  in  NUM_PLAT_IRQ  level interrupt requests.
- rd_data  out  XLEN  old CSR value, combinational.
- illegal_csr  out  1  csr_valid to an unimplemented address.
- excep_taken  out  1  redirect fetch this cycle.
- excep_pc  out  XLEN  redirect target.

## Operation
- Implemented CSRs and their reset values:
  - mstatus 0x300 (reset 0x1800): MIE[3] and MPIE[7] are R/W; MPP[12:11] is hardwired to 11; all other bits read 0.
  - mie 0x304 (reset 0): bits 3, 7, 11, [16+N-1:16] are R/W.
  - mtvec 0x305 (reset 0): [31:2] base and [0] mode are R/W; [1] reads 0.
  - mscratch 0x340 (reset 0): full R/W.
  - mepc 0x341 (reset 0): [1:0] read 0.
  - mcause 0x342 (reset 0): full R/W.
  - mip 0x344 (reset 0): only MSIP[3] is writable; bits 7, 11, [16+N-1:16] are read-only sampled copies of timer_irq, ext_irq, plat_irq.
  - mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82 (reset 0).
- Write value is computed from old, where old is the current register value:
  - RW/RWI: wdata.
  - RS/RSI: old | wdata.
  - RC/RCI: old & ~wdata.
  - Read-only and hardwired bits are masked after the operation.
  - RS/RC(I) with wdata==0 performs no write.
- rd_data returns old when csr_valid is 1 and the address is implemented; otherwise rd_data is 0.
- An unimplemented address asserts illegal_csr, performs no write, and rd_data=0.
- Counters:
  - mcycle increments every cycle.
  - minstret increments when instr_retire is 1.
  - Each counter wraps at 2^64 to 0.
  - A CSR write to either half wins over the increment in that cycle; the other half still holds or carries normally.
- pend = mip & mie.
  - Priority, highest first: MEI(11), MSI(3), MTI(7), then plat_irq[0] up to plat_irq[N-1].
  - cause code = bit index.
- Trap FSM states: RUN, SETTLE.
  - RUN, is_mret=1 (always wins over an interrupt):
    - excep_taken=1, excep_pc=mepc.
    - At the edge: MIE<=MPIE, MPIE<=1.
    - Next state SETTLE.
  - RUN, otherwise, if MIE & |pend & can_take:
    - excep_taken=1.
    - excep_pc = mtvec base, or base + 4*code if mode=1.
    - At the edge: mepc<=pc & ~3, mcause<={1'b1, 26'b0, code[4:0]}, MPIE<=MIE, MIE<=0.
    - Next state SETTLE.
  - SETTLE: excep_taken=0, no trap or mret accepted, then RUN.
- A CSR write or instr_retire coinciding with excep_taken=1 is discarded, because the instruction is flushed. mcycle still increments.
- An interrupt with can_take=0 stays pending; it is re-evaluated each cycle and nothing latches.

## Timing
- Reset values:
  - rd_data=0, illegal_csr=0, excep_taken=0, excep_pc=0 (base 0).
  - FSM=RUN, counters 0.
  - Reset mid-trap returns to RUN immediately, asynchronously.
- rd_data, illegal_csr, excep_taken, excep_pc are combinational from registered state and current inputs.
- Interrupt latency:
  - An IRQ high before edge E sets its mip bit after E.
  - excep_taken can be high in the cycle after E, i.e. 1 cycle input-to-redirect.
  - The earliest next redirect is 2 cycles after any redirect.
- A CSR write becomes visible to reads and to trap logic the cycle after its edge.
- An mie/mstatus write enabling an already-pending interrupt traps the following cycle.
- An IRQ dropping before trap entry cancels the trap; no latch.

## Test plan
- CSR RMW: RW mscratch 0xA5A5_0000; RS 0x0000_00FF; RC 0xA500_0000. Reads return 0, 0xA5A5_0000, 0xA5A5_00FF. The final value is 0x00A5_00FF.
- mstatus masking: RW mstatus 0xFFFF_FFFF. The read-back is 0x0000_1888. RC 0x1800 leaves it at 0x1888.
- Vectored interrupt:
  - Setup: mtvec=0x0000_1001, mie=0x800, mstatus.MIE=1, pc=0x200. Raise ext_irq.
  - Result, the next cycle: excep_taken=1 and excep_pc=0x102C.
  - Afterwards: mepc=0x200, mcause=0x8000_000B, mstatus=0x1880.
  - The following cycle excep_taken=0.
- Priority and masking:
  - timer_irq, ext_irq, and plat_irq[2] asserted together with mie=0x40880: cause 11.
  - After clearing mie[11]: cause 7.
  - With MIE=0: no trap.
- mret and collision:
  - Inside the handler, is_mret with ext_irq still pending: excep_pc=mepc and MIE is restored to 1.
  - SETTLE blocks the interrupt for 1 cycle; it re-traps the cycle after.
- Counters:
  - Write mcycle=0xFFFF_FFFE, mcycleh=0xFFFF_FFFF. Two cycles later mcycle=0 and mcycleh=0, showing the 64-bit wrap.
  - minstret counts only instr_retire pulses, excluding one discarded in a trap cycle.
  - Address 0x7C0 gives illegal_csr=1 with no state change.
